// File: rtl/receiver_pkg.sv
// receiver_pkg
// Shared constants, the FIFO entry layout and the parity-check helper for
// the UART receive buffer.
`timescale 1ns/1ps
package receiver_pkg;

  localparam int DATA_W  = 8;
  localparam int FRAME_W = 9;

  // One stored FIFO entry: parity-error flag above the data byte.
  typedef struct packed {
    logic              perr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Returns 1 when the frame's parity does not match the expected sense.
  // odd = 0 expects an even number of ones across all nine bits.
  function automatic logic parity_err(input logic [FRAME_W-1:0] frame,
                                      input logic               odd);
    return (^frame) ^ odd;
  endfunction

endpackage

// File: rtl/receiver_buffer_ready_sync.sv
// ready_sync
// Brings an asynchronous level into the clk domain through two flops and
// emits a one-cycle pulse on each rising edge of the synchronized level.
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-high reset (all flops to 0)
//   level  in   asynchronous level to synchronize
//   pulse  out  one clk-wide pulse per rising edge of level
`timescale 1ns/1ps
module ready_sync (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
    end else begin
      sync1_reg <= level;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
    end
  end

  // Because the chain resets to 0, a level already high at reset release
  // is reported as a fresh rising edge.
  assign pulse = sync2_reg & ~sync3_reg;

endmodule

// File: rtl/receiver_buffer.sv
// receiver_buffer
// Takes each completed frame from the UART receiver, checks its parity and
// queues {perr, data} in a DEPTH-entry FIFO read through a valid/ready port.
// A frame arriving while the FIFO is full (and no pop that cycle) is dropped
// and raises a sticky overrun flag.
// Ports:
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   dataParityIn  in   [7:0] data, [8] parity bit
//   rxReady       in   asynchronous frame-complete level
//   rdReady       in   host accepts head entry
//   rdValid       out  head entry present
//   rdData        out  head entry data (0 when empty)
//   rdPerr        out  head entry parity error (0 when empty)
//   level         out  entry count 0..DEPTH
//   overrun       out  sticky dropped-frame flag
//   clrOverrun    in   clears overrun (a new drop wins)
`timescale 1ns/1ps
module receiver_buffer
  import receiver_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [FRAME_W-1:0]       dataParityIn,
  input  logic                     rxReady,
  input  logic                     rdReady,
  output logic                     rdValid,
  output logic [DATA_W-1:0]        rdData,
  output logic                     rdPerr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  input  logic                     clrOverrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic            push;
  logic            pop;
  logic            full;
  logic            do_write;
  logic            drop;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            overrun_reg;
  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          new_entry;

  ready_sync u_ready_sync (
    .clk   (clk),
    .rst   (rst),
    .level (rxReady),
    .pulse (push)
  );

  assign rdValid  = (level_reg != '0);
  assign pop      = rdValid & rdReady;
  assign full     = (level_reg == LW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  assign new_entry.perr = parity_err(dataParityIn, (PARITY_ODD != 0));
  assign new_entry.data = dataParityIn[DATA_W-1:0];

  // Storage is not reset; entries are only visible while level counts them.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr_reg] <= new_entry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      level_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      if (do_write && !pop) begin
        level_reg <= level_reg + LW'(1);
      end else if (pop && !do_write) begin
        level_reg <= level_reg - LW'(1);
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (clrOverrun) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign head    = mem[rd_ptr_reg];
  assign rdData  = rdValid ? head.data : '0;
  assign rdPerr  = rdValid ? head.perr : 1'b0;
  assign level   = level_reg;
  assign overrun = overrun_reg;

endmodule
